// File: rtl/pwl_sample_mixer.sv
`default_nettype none
// ============================================================================
// Module      : pwl_sample_mixer
// Description : Sums one signed sample per channel per frame into an 8-bit
//               offset-binary level driving double-buffered PWM and 1st-order PDM.
// Revision    : 1.0 - initial release
// ============================================================================
module pwl_sample_mixer #(
    parameter int NUM_CHANNELS = 4,
    parameter int CH_BITS      = 2,
    parameter int SAMPLE_BITS  = 10,
    parameter int OUT_BITS     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CH_BITS-1:0]     in_channel,
    input  logic [SAMPLE_BITS-1:0] in_sample,
    input  logic                   in_last,
    output logic [OUT_BITS-1:0]    out_sample,
    output logic                   out_strobe,
    output logic                   pwm_out,
    output logic                   pdm_out,
    output logic                   mix_error
);

    localparam int c_ACC_BITS = SAMPLE_BITS + CH_BITS;
    localparam logic [OUT_BITS-1:0] c_OFFSET = {1'b1, {(OUT_BITS-1){1'b0}}};
    localparam logic [0:0] c_ST_ACCUM = 1'b0;
    localparam logic [0:0] c_ST_DRAIN = 1'b1;

    logic [0:0]              r_state;
    logic [0:0]              w_state_nxt;
    logic [c_ACC_BITS-1:0]   r_acc;
    logic [NUM_CHANNELS-1:0] r_mask;
    logic [OUT_BITS-1:0]     r_out_sample;
    logic                    r_out_strobe;
    logic                    r_mix_error;
    logic [OUT_BITS-1:0]     r_pwm_cnt;
    logic [OUT_BITS-1:0]     r_pwm_level;
    logic                    r_pwm_out;
    logic [OUT_BITS-1:0]     r_sd_acc;
    logic                    r_pdm_out;

    logic                    w_xfer;
    logic                    w_dup;
    logic [c_ACC_BITS-1:0]   w_sample_ext;
    logic [OUT_BITS-1:0]     w_level;
    logic [OUT_BITS:0]       w_sd_sum;

    assign in_ready     = (r_state == c_ST_ACCUM);
    assign w_xfer       = in_valid && in_ready;
    assign w_dup        = r_mask[in_channel];
    assign w_sample_ext = {{CH_BITS{in_sample[SAMPLE_BITS-1]}}, in_sample};

    // Arithmetic floor shift of the sum is just its top OUT_BITS bits.
    assign w_level  = r_acc[c_ACC_BITS-1 -: OUT_BITS] + c_OFFSET;
    assign w_sd_sum = {1'b0, r_sd_acc} + {1'b0, r_out_sample};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_ACCUM: if (w_xfer && in_last) w_state_nxt = c_ST_DRAIN;
            c_ST_DRAIN: w_state_nxt = c_ST_ACCUM;
            default:    w_state_nxt = c_ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_ACCUM;
            r_acc        <= '0;
            r_mask       <= '0;
            r_out_sample <= c_OFFSET;
            r_out_strobe <= 1'b0;
            r_mix_error  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_out_strobe <= 1'b0;
            if (r_state == c_ST_DRAIN) begin
                r_out_sample <= w_level;
                r_out_strobe <= 1'b1;
                r_acc        <= '0;
                r_mask       <= '0;
            end else if (w_xfer) begin
                if (w_dup) begin
                    r_mix_error <= 1'b1;
                end else begin
                    r_acc              <= r_acc + w_sample_ext;
                    r_mask[in_channel] <= 1'b1;
                end
            end
        end
    end

    // The level is only reloaded at the period boundary so a period is never split.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwm_cnt   <= '0;
            r_pwm_level <= c_OFFSET;
            r_pwm_out   <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (&r_pwm_cnt) r_pwm_level <= r_out_sample;
            r_pwm_out <= (r_pwm_cnt < r_pwm_level);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sd_acc  <= '0;
            r_pdm_out <= 1'b0;
        end else begin
            r_sd_acc  <= w_sd_sum[OUT_BITS-1:0];
            r_pdm_out <= w_sd_sum[OUT_BITS];
        end
    end

    assign out_sample = r_out_sample;
    assign out_strobe = r_out_strobe;
    assign mix_error  = r_mix_error;
    assign pwm_out    = r_pwm_out;
    assign pdm_out    = r_pdm_out;

endmodule
`default_nettype wire

// File: tb/tb_pwl_sample_mixer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwl_sample_mixer
// Description : Self-checking bench: frame table with strobe-driven scoreboard
//               plus hand sequences for timing, PWM, PDM and reset corners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwl_sample_mixer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_channel;
    logic [9:0] in_sample;
    logic       in_last;
    logic [7:0] out_sample;
    logic       out_strobe;
    logic       pwm_out;
    logic       pdm_out;
    logic       mix_error;

    pwl_sample_mixer #(
        .NUM_CHANNELS(4), .CH_BITS(2), .SAMPLE_BITS(10), .OUT_BITS(8)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_channel(in_channel), .in_sample(in_sample), .in_last(in_last),
        .out_sample(out_sample), .out_strobe(out_strobe), .pwm_out(pwm_out),
        .pdm_out(pdm_out), .mix_error(mix_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             n;
        logic [3:0][1:0] ch;
        logic [3:0][9:0] s;
        logic [7:0]     exp_level;
        logic           exp_err;
    } vec_t;

    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] sb[$];
    logic [7:0] tb_cnt;

    // Bench-side reference for the PWM period phase.
    always @(posedge clk) tb_cnt <= reset ? 8'd0 : tb_cnt + 8'd1;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!reset && out_strobe) begin
            if (sb.size() == 0) check("unexpected_strobe", 1, 0);
            else check("frame_level", int'(out_sample), int'(sb.pop_front()));
        end
    end

    function automatic vec_t mk(input int n, input int c0, input int c1, input int c2,
                                input int c3, input int s0, input int s1, input int s2,
                                input int s3, input int e, input bit err);
        vec_t v;
        v.n = n;
        v.ch[0] = 2'(c0); v.ch[1] = 2'(c1); v.ch[2] = 2'(c2); v.ch[3] = 2'(c3);
        v.s[0] = 10'(s0); v.s[1] = 10'(s1); v.s[2] = 10'(s2); v.s[3] = 10'(s3);
        v.exp_level = 8'(e);
        v.exp_err = err;
        return v;
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after the transfer.
    task automatic xfer(input logic [1:0] ch, input logic [9:0] s, input logic last);
        int k;
        in_valid = 1'b1; in_channel = ch; in_sample = s; in_last = last;
        k = 0;
        while (!in_ready && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) check("xfer_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_frame(input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            if (i == v.n - 1) sb.push_back(v.exp_level);
            xfer(v.ch[i], v.s[i], (i == v.n - 1));
        end
    endtask

    task automatic wait_sb();
        for (int k = 0; k < 20 && sb.size() > 0; k++) begin
            @(posedge clk); #1;
        end
        if (sb.size() > 0) begin
            check("strobe_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic check_reset_vals();
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_sample", int'(out_sample), 128);
        check("rst_out_strobe", int'(out_strobe), 0);
        check("rst_mix_error", int'(mix_error), 0);
        check("rst_pwm_out", int'(pwm_out), 0);
        check("rst_pdm_out", int'(pdm_out), 0);
    endtask

    task automatic count_ones(input bit use_pwm, output int ones, output int alt_err);
        logic prev;
        ones = 0; alt_err = 0;
        prev = use_pwm ? pwm_out : pdm_out;
        for (int i = 0; i < 256; i++) begin
            logic b;
            b = use_pwm ? pwm_out : pdm_out;
            if (b) ones++;
            if (i > 0 && b == prev) alt_err++;
            prev = b;
            @(posedge clk); #1;
        end
    endtask

    vec_t vecs[7];
    vec_t v64, v511, v0, vmid;
    int   ones, alt, ones2;

    initial begin
        vecs[0] = mk(4, 0, 1, 2, 3, 100, 200, -50, 0, 143, 1'b0);
        vecs[1] = mk(4, 0, 1, 2, 3, 511, 511, 511, 511, 255, 1'b0);
        vecs[2] = mk(4, 0, 1, 2, 3, -512, -512, -512, -512, 0, 1'b0);
        vecs[3] = mk(1, 0, 0, 0, 0, -1, 0, 0, 0, 127, 1'b0);
        vecs[4] = mk(4, 3, 2, 1, 0, 0, 0, 0, 0, 128, 1'b0);
        vecs[5] = mk(3, 0, 0, 1, 0, 16, 32, 16, 0, 130, 1'b1);
        vecs[6] = mk(1, 2, 0, 0, 0, -32, 0, 0, 0, 126, 1'b1);
        v64  = mk(2, 0, 1, 0, 0, -512, -512, 0, 0, 64, 1'b0);
        v511 = vecs[1];
        v0   = vecs[2];
        vmid = mk(1, 1, 0, 0, 0, 16, 0, 0, 0, 129, 1'b0);

        reset = 1'b1; in_valid = 1'b0; in_channel = '0; in_sample = '0; in_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        reset = 1'b0;
        @(posedge clk); #1;
        check("pwm_second_cycle", int'(pwm_out), 1);
        check("pdm_second_cycle", int'(pdm_out), 0);

        // Handshake timing around the drain cycle.
        xfer(2'd0, 10'd100, 1'b0);
        xfer(2'd1, 10'd200, 1'b0);
        xfer(2'd2, 10'(-50), 1'b0);
        sb.push_back(8'd143);
        xfer(2'd3, 10'd0, 1'b1);
        check("drain_in_ready", int'(in_ready), 0);
        check("drain_strobe", int'(out_strobe), 0);
        @(posedge clk); #1;
        check("t2_in_ready", int'(in_ready), 1);
        check("t2_strobe", int'(out_strobe), 1);
        check("t2_out_sample", int'(out_sample), 143);
        @(posedge clk); #1;
        check("t3_strobe", int'(out_strobe), 0);
        wait_sb();

        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i]);
            wait_sb();
            check($sformatf("vec%0d_mix_error", i), int'(mix_error), int'(vecs[i].exp_err));
        end

        // PWM: level 64, then a mid-period change that must wait for the wrap.
        send_frame(v64);
        wait_sb();
        for (int k = 0; k < 300 && tb_cnt != 8'd255; k++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        fork
            count_ones(1'b1, ones, alt);
            begin
                repeat (100) @(posedge clk);
                #1;
                send_frame(v511);
            end
        join
        wait_sb();
        check("pwm_ones_64", ones, 64);
        count_ones(1'b1, ones2, alt);
        check("pwm_ones_255_next_period", ones2, 255);

        // PDM densities.
        send_frame(vecs[4]);
        wait_sb();
        repeat (2) @(posedge clk);
        #1;
        count_ones(1'b0, ones, alt);
        check("pdm_ones_128", ones, 128);
        check("pdm_alternation_errors", alt, 0);
        send_frame(v0);
        wait_sb();
        repeat (2) @(posedge clk);
        #1;
        count_ones(1'b0, ones, alt);
        check("pdm_ones_0", ones, 0);
        send_frame(v511);
        wait_sb();
        repeat (2) @(posedge clk);
        #1;
        count_ones(1'b0, ones, alt);
        check("pdm_ones_255", ones, 255);

        // Reset mid-frame discards the partial sum and clears mix_error.
        check("pre_reset_mix_error", int'(mix_error), 1);
        xfer(2'd0, 10'd200, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_vals();
        reset = 1'b0;
        @(posedge clk); #1;
        check("pwm_second_cycle_2", int'(pwm_out), 1);
        send_frame(vmid);
        wait_sb();
        check("post_reset_mix_error", int'(mix_error), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
